// File: rtl/draw_pkg.sv
// Shared types, screen geometry and FSM encoding for the projected-triangle path.
package draw_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned COORD_W  = 16;
   localparam int unsigned PIX_W    = 10;
   localparam int unsigned DIV_W    = 26;
   localparam int unsigned MAP_W    = 28;

   typedef logic signed [2:0][COORD_W-1:0] vertex3_t;
   typedef logic [2:0][1:0][PIX_W-1:0]     proj_tri_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_CHECK,
      ST_DIV,
      ST_CULL,
      ST_PUSH,
      ST_DONE
   } state_e;

   // Clamp a signed screen coordinate into [0, lim-1].
   function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [MAP_W-1:0] v,
                                                  input int unsigned lim);
      logic signed [MAP_W-1:0] hi;
      logic [PIX_W-1:0]        res;
      hi = $signed(MAP_W'(lim - 1));
      if (v[MAP_W-1])
         res = '0;
      else if (v > hi)
         res = PIX_W'(lim - 1);
      else
         res = v[PIX_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, first bit resolved on the start edge.
module seq_divider
   import draw_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [DIV_W-1:0] num,
   input  logic [DIV_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [DIV_W-1:0] quot
);

   localparam int unsigned CNT_W = 5;

   logic [DIV_W:0]   rem_q, rem_d;
   logic [DIV_W-1:0] quo_q, quo_d;
   logic [DIV_W-1:0] den_q, den_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             load;
   logic [DIV_W:0]   step_rem;
   logic [DIV_W-1:0] step_quo;
   logic [DIV_W-1:0] step_den;
   logic [DIV_W:0]   trial;

   assign load = start && !busy_q;

   always_comb begin
      rem_d    = rem_q;
      quo_d    = quo_q;
      den_d    = den_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      step_rem = rem_q;
      step_quo = quo_q;
      step_den = den_q;

      if (load) begin
         step_rem = '0;
         step_quo = num;
         step_den = den;
         den_d    = den;
         cnt_d    = CNT_W'(DIV_W - 1);
         busy_d   = 1'b1;
      end else if (busy_q) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end

      // Numerator bits shift out of the top of quo while quotient bits shift in below.
      trial = {step_rem[DIV_W-1:0], step_quo[DIV_W-1]};
      if (load || busy_q) begin
         if (trial >= {1'b0, step_den}) begin
            rem_d = trial - {1'b0, step_den};
            quo_d = {step_quo[DIV_W-2:0], 1'b1};
         end else begin
            rem_d = trial;
            quo_d = {step_quo[DIV_W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rem_q  <= '0;
         quo_q  <= '0;
         den_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         den_q  <= den_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quo_q;

endmodule

// File: rtl/tri_project_writer.sv
// Perspective-projects streamed triangles, drops near-plane crossers and writes triangle_fifo.
// Optional BACKFACE_CULL_EN adds a signed-area cull stage after the divides.
module tri_project_writer
   import draw_pkg::*;
#(
   parameter logic [9:0] FOCAL = 10'd256,
   parameter int         CX    = 320,
   parameter int         CY    = 240,
   parameter int         ZNEAR = 1
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        start,
   input  logic                        tri_valid,
   output logic                        tri_ready,
   input  logic                        tri_last,
   input  logic [2:0][2:0][COORD_W-1:0] tri_xyz,
   input  logic                        fifo_full,
   output logic                        fifo_w,
   output proj_tri_t                   proj_triangle_in,
   output logic                        proj_done,
   output logic [15:0]                 drop_count
);

   state_e          state_q, state_d;
   vertex3_t [2:0]  xyz_q, xyz_d;
   logic            last_q, last_d;
   logic [2:0]      idx_q, idx_d;
   proj_tri_t       scr_q, scr_d;
   proj_tri_t       proj_q, proj_d;
   logic [15:0]     drop_q, drop_d, drop_inc;
   logic            ready_q, done_q;

   logic                     div_start, div_busy, div_done;
   logic [DIV_W-1:0]         div_quot, num_mag, den_mag;
   logic [1:0]               vsel;
   logic                     csel;
   logic signed [COORD_W-1:0] coord;
   logic signed [DIV_W-1:0]  prod, q_s;
   logic                     num_neg;
   logic signed [MAP_W-1:0]  q_w, scr_x, scr_y;
   logic [PIX_W-1:0]         pix;
   logic                     clip;

   // idx walks v0x,v0y,v1x,v1y,v2x,v2y.
   assign vsel    = idx_q[2:1];
   assign csel    = idx_q[0];
   assign coord   = $signed(xyz_q[vsel][csel]);
   assign prod    = DIV_W'(coord) * $signed(DIV_W'(FOCAL));
   assign num_neg = prod[DIV_W-1];
   assign num_mag = num_neg ? DIV_W'(-prod) : DIV_W'(prod);
   assign den_mag = DIV_W'(xyz_q[vsel][2]);
   assign q_s     = num_neg ? -$signed(div_quot) : $signed(div_quot);
   assign q_w     = MAP_W'(q_s);
   assign scr_x   = $signed(MAP_W'(CX)) + q_w;
   assign scr_y   = $signed(MAP_W'(CY)) - q_w;
   assign pix     = csel ? clamp_pix(scr_y, SCREEN_H) : clamp_pix(scr_x, SCREEN_W);

   assign div_start = (state_q == ST_DIV) && !div_busy && !div_done;
   assign drop_inc  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

   always_comb begin
      clip = 1'b0;
      for (int v = 0; v < 3; v++) begin
         if (int'($signed(xyz_q[v][2])) < ZNEAR)
            clip = 1'b1;
      end
   end

`ifdef BACKFACE_CULL_EN
   localparam int unsigned AREA_W = 22;
   logic signed [AREA_W-1:0] dx1, dy1, dx2, dy2, area;
   logic                     area_pos;

   always_comb begin
      dx1  = $signed(AREA_W'(scr_q[1][0])) - $signed(AREA_W'(scr_q[0][0]));
      dy1  = $signed(AREA_W'(scr_q[1][1])) - $signed(AREA_W'(scr_q[0][1]));
      dx2  = $signed(AREA_W'(scr_q[2][0])) - $signed(AREA_W'(scr_q[0][0]));
      dy2  = $signed(AREA_W'(scr_q[2][1])) - $signed(AREA_W'(scr_q[0][1]));
      area = dx1 * dy2 - dx2 * dy1;
   end
   assign area_pos = !area[AREA_W-1] && (area != '0);
`endif

   seq_divider u_div (
      .Clk   (Clk),
      .Reset (Reset),
      .start (div_start),
      .num   (num_mag),
      .den   (den_mag),
      .busy  (div_busy),
      .done  (div_done),
      .quot  (div_quot)
   );

   always_comb begin
      state_d = state_q;
      xyz_d   = xyz_q;
      last_d  = last_q;
      idx_d   = idx_q;
      scr_d   = scr_q;
      proj_d  = proj_q;
      drop_d  = drop_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               drop_d  = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (tri_valid && ready_q) begin
               xyz_d   = tri_xyz;
               last_d  = tri_last;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (clip) begin
               drop_d  = drop_inc;
               state_d = last_q ? ST_DONE : ST_RUN;
            end else begin
               idx_d   = '0;
               state_d = ST_DIV;
            end
         end
         ST_DIV: begin
            if (div_done) begin
               scr_d[vsel][csel] = pix;
               if (idx_q == 3'd5) begin
`ifdef BACKFACE_CULL_EN
                  state_d = ST_CULL;
`else
                  state_d = ST_PUSH;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef BACKFACE_CULL_EN
         ST_CULL: begin
            if (area_pos) begin
               state_d = ST_PUSH;
            end else begin
               drop_d  = drop_inc;
               state_d = last_q ? ST_DONE : ST_RUN;
            end
         end
`endif
         ST_PUSH: begin
            if (!fifo_full)
               state_d = last_q ? ST_DONE : ST_RUN;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Output triangle only changes as a push begins, so it stays stable through the write.
      if ((state_d == ST_PUSH) && (state_q != ST_PUSH))
         proj_d = scr_d;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         xyz_q   <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         scr_q   <= '0;
         proj_q  <= '0;
         drop_q  <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xyz_q   <= xyz_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         scr_q   <= scr_d;
         proj_q  <= proj_d;
         drop_q  <= drop_d;
         ready_q <= (state_d == ST_RUN);
         done_q  <= (state_d == ST_DONE);
      end
   end

   // Write enable must see the current full flag, so it is gated directly.
   assign fifo_w           = (state_q == ST_PUSH) && !fifo_full;
   assign tri_ready        = ready_q;
   assign proj_done        = done_q;
   assign proj_triangle_in = proj_q;
   assign drop_count       = drop_q;

endmodule

// File: tb/tb_tri_project_writer.sv
// Directed plus randomized checks of tri_project_writer against an arithmetic projection model.
module tb_tri_project_writer;
   import draw_pkg::*;

   typedef logic [2:0][2:0][15:0] tri_t;

`ifdef BACKFACE_CULL_EN
   localparam int CULL = 1;
`else
   localparam int CULL = 0;
`endif

   logic      Clk, Reset, start, tri_valid, tri_ready, tri_last, fifo_full, fifo_w, proj_done;
   tri_t      tri_xyz;
   proj_tri_t proj_triangle_in;
   logic [15:0] drop_count;

   int        nvec  = 0;
   int        nfail = 0;
   int        exp_drop = 0;
   proj_tri_t exp_proj = '0;

   tri_project_writer dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .start            (start),
      .tri_valid        (tri_valid),
      .tri_ready        (tri_ready),
      .tri_last         (tri_last),
      .tri_xyz          (tri_xyz),
      .fifo_full        (fifo_full),
      .fifo_w           (fifo_w),
      .proj_triangle_in (proj_triangle_in),
      .proj_done        (proj_done),
      .drop_count       (drop_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic tri_t mk(input int x0, input int y0, input int z0,
                               input int x1, input int y1, input int z1,
                               input int x2, input int y2, input int z2);
      tri_t t;
      t[0][0] = 16'(x0); t[0][1] = 16'(y0); t[0][2] = 16'(z0);
      t[1][0] = 16'(x1); t[1][1] = 16'(y1); t[1][2] = 16'(z1);
      t[2][0] = 16'(x2); t[2][1] = 16'(y2); t[2][2] = 16'(z2);
      return t;
   endfunction

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   // Reference: pinhole projection with truncating integer divide, clamp, signed area.
   function automatic void model(input tri_t t, output bit clip, output proj_tri_t p,
                                 output int area);
      int sx[3];
      int sy[3];
      clip = 1'b0;
      p    = '0;
      for (int v = 0; v < 3; v++)
         if (int'($signed(t[v][2])) < 1) clip = 1'b1;
      for (int v = 0; v < 3; v++) begin
         int z;
         z     = clip ? 1 : int'($signed(t[v][2]));
         sx[v] = clampi(320 + (int'($signed(t[v][0])) * 256) / z, 639);
         sy[v] = clampi(240 - (int'($signed(t[v][1])) * 256) / z, 479);
         p[v][0] = 10'(sx[v]);
         p[v][1] = 10'(sy[v]);
      end
      area = (sx[1] - sx[0]) * (sy[2] - sy[0]) - (sx[2] - sx[0]) * (sy[1] - sy[0]);
   endfunction

   task automatic run_tri(input tri_t t, input bit last, input int full_cyc,
                          output int nw, output int wlat, output proj_tri_t got,
                          output int endlat, output int bad);
      nw = 0; wlat = -1; got = '0; endlat = -1; bad = 0;
      @(negedge Clk);
      tri_xyz = t; tri_last = last; tri_valid = 1'b1;
      #1;
      if (!tri_ready) bad++;
      @(posedge Clk);
      #1;
      tri_valid = 1'b0; tri_last = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge Clk);
         fifo_full = (k >= 164 + CULL) && (k < 164 + CULL + full_cyc);
         #1;
         if (fifo_w) begin
            nw++;
            wlat = k;
            got  = proj_triangle_in;
            if (fifo_full) bad++;
         end
         if (last ? proj_done : tri_ready) begin
            endlat = k;
            break;
         end
         if (tri_ready) bad++;
      end
      fifo_full = 1'b0;
   endtask

   task automatic do_tri(input string tag, input tri_t t, input bit last, input int full_cyc);
      bit        clip, push;
      proj_tri_t p, got;
      int        area, exp_w, exp_end, nw, wlat, endlat, bad;
      model(t, clip, p, area);
      push    = !clip && ((CULL == 0) || (area > 0));
      exp_w   = push ? 164 + CULL + full_cyc : -1;
      exp_end = clip ? 2 : (push ? exp_w + 1 : 165);
      if (push) exp_proj = p;
      else if (exp_drop < 16'hFFFF) exp_drop++;
      run_tri(t, last, full_cyc, nw, wlat, got, endlat, bad);
      chk({tag, ".nw"}, nw, 64'(push));
      chk({tag, ".wlat"}, wlat, exp_w);
      if (push) chk({tag, ".pushed"}, got, p);
      chk({tag, ".proj"}, proj_triangle_in, exp_proj);
      chk({tag, ".end"}, endlat, exp_end);
      chk({tag, ".drop"}, drop_count, exp_drop);
      chk({tag, ".proto"}, bad, 0);
   endtask

   task automatic do_start();
      @(negedge Clk);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      #1;
      exp_drop = 0;
      chk("start.ready", tri_ready, 1);
      chk("start.drop", drop_count, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".ready"}, tri_ready, 0);
      chk({tag, ".fifo_w"}, fifo_w, 0);
      chk({tag, ".done"}, proj_done, 0);
      chk({tag, ".proj"}, proj_triangle_in, 0);
      chk({tag, ".drop"}, drop_count, 0);
   endtask

   initial begin
      tri_t t1, t;
      Reset = 1'b1; start = 1'b0; tri_valid = 1'b0; tri_last = 1'b0;
      fifo_full = 1'b0; tri_xyz = '0;
      t1 = mk(0, 0, 100, 100, 50, 200, -100, -50, 200);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk_reset_outputs("por");

      do_start();
      do_tri("basic", t1, 1'b1, 0);

      do_start();
      do_tri("clamp", mk(1000, 0, 10, 0, -1000, 10, 5, 5, 10), 1'b1, 0);

      do_start();
      do_tri("znear", mk(0, 0, 0, 1, 1, 5, 2, 2, 5), 1'b1, 0);

      do_start();
      do_tri("full", mk(0, 0, 100, -100, 50, 200, 100, 50, 200), 1'b1, 10);

      do_start();
      do_tri("orient", mk(0, 0, 100, 100, 50, 200, -100, 50, 200), 1'b0, 0);
      do_tri("pre_rst", mk(3, 3, -2, 1, 1, 5, 2, 2, 5), 1'b0, 0);
      @(negedge Clk);
      tri_xyz = t1; tri_last = 1'b1; tri_valid = 1'b1;
      @(posedge Clk);
      #1;
      tri_valid = 1'b0; tri_last = 1'b0;
      repeat (50) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk_reset_outputs("mid_div_rst");
      exp_proj = '0;
      exp_drop = 0;
      repeat (3) @(negedge Clk);
      #1;
      chk("post_rst.idle", tri_ready, 0);
      do_start();
      do_tri("after_rst", t1, 1'b1, 0);

      do_start();
      for (int i = 0; i < 24; i++) begin
         for (int v = 0; v < 3; v++) begin
            t[v][0] = 16'(int'($urandom_range(0, 4000)) - 2000);
            t[v][1] = 16'(int'($urandom_range(0, 4000)) - 2000);
            if ($urandom_range(0, 9) == 0)
               t[v][2] = 16'(-int'($urandom_range(0, 5)));
            else
               t[v][2] = 16'(int'($urandom_range(1, 400)));
         end
         do_tri("rnd", t, i == 23, (i % 5 == 0) ? int'($urandom_range(1, 6)) : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
